// File: rtl/ins_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encodings, halt word, stream byte order.
// Included by the loader RTL and by any CPU-level bench that needs the same encodings.
package ins_mem_loader_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_HDR_HI  = 3'd1;
   localparam logic [2:0] ST_HDR_LO  = 3'd2;
   localparam logic [2:0] ST_DATA_HI = 3'd3;
   localparam logic [2:0] ST_DATA_LO = 3'd4;
   localparam logic [2:0] ST_CHK     = 3'd5;
   localparam logic [2:0] ST_RUN     = 3'd6;
   localparam logic [2:0] ST_ERR     = 3'd7;

   localparam int unsigned DEPTH_LOG2_DEFAULT = 8;
   // sys/halt opcode 4'b1101 with a zero operand field
   localparam logic [15:0] HALT_WORD_DEFAULT  = 16'hD000;

   typedef logic [15:0] ins_word_t;

   // Words travel high byte first on the stream.
   typedef struct packed {
      logic [7:0] hi;
      logic [7:0] lo;
   } word_bytes_t;

   function automatic ins_word_t make_word(input logic [7:0] hi, input logic [7:0] lo);
      word_bytes_t w;
      w.hi = hi;
      w.lo = lo;
      return ins_word_t'(w);
   endfunction

endpackage

// File: rtl/ins_mem_loader_if.sv
// Fetch port and byte-stream load handshake of the instruction-memory loader.
// master = CPU/board side, slave = loader.
interface ins_mem_loader_if;

   logic [15:0] ins_addr;
   logic [15:0] ins;
   logic        cpu_clear;
   logic        load_start;
   logic        load_valid;
   logic [7:0]  load_byte;
   logic        load_ready;
   logic        load_done;
   logic        load_err;

   modport master (
      output ins_addr, load_start, load_valid, load_byte,
      input  ins, cpu_clear, load_ready, load_done, load_err
   );

   modport slave (
      input  ins_addr, load_start, load_valid, load_byte,
      output ins, cpu_clear, load_ready, load_done, load_err
   );

endinterface

// File: rtl/ins_mem_loader_ram.sv
// Instruction RAM: 2**DEPTH_LOG2 x 16, synchronous write, asynchronous read.
// No reset on the array so a clear leaves its contents in place.
module ins_mem_loader_ram #(
   parameter int unsigned DEPTH_LOG2 = 8
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] waddr,
   input  logic [15:0]           wdata,
   input  logic [DEPTH_LOG2-1:0] raddr,
   output logic [15:0]           rdata
);

   logic [15:0] mem [0:(1 << DEPTH_LOG2)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/ins_mem_loader.sv
// Loads a program from a byte stream into instruction RAM and serves CPU fetches from it.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before releasing the CPU.
module ins_mem_loader
   import ins_mem_loader_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEFAULT,
   parameter logic [15:0] HALT_WORD  = HALT_WORD_DEFAULT
) (
   input  logic           clk,
   input  logic           clear,
   ins_mem_loader_if.slave bus
);

   localparam int          WP_W      = DEPTH_LOG2 + 1;
   localparam logic [16:0] MAX_WORDS = 17'(1) << DEPTH_LOG2;

`ifdef LOADER_CHECKSUM_EN
   localparam logic [2:0] ST_DONE = ST_CHK;
`else
   localparam logic [2:0] ST_DONE = ST_RUN;
`endif

   logic [2:0]      state_reg, state_next;
   logic [15:0]     n_reg, n_next;
   logic [15:0]     count_reg, count_next;
   logic [WP_W-1:0] wptr_reg, wptr_next;
   logic [7:0]      hi_reg, hi_next;
   logic            cpu_clear_reg;
   logic            load_done_reg;
   logic            load_err_reg;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]      csum_reg, csum_next;
`endif

   logic            ready;
   logic            accept;
   logic            ram_we;
   logic [15:0]     ram_wdata;
   logic [15:0]     ram_rdata;
   logic [15:0]     n_hdr;
   logic [15:0]     wptr_ext;

   assign ready = (state_reg == ST_HDR_HI)  || (state_reg == ST_HDR_LO)  ||
                  (state_reg == ST_DATA_HI) || (state_reg == ST_DATA_LO) ||
                  (state_reg == ST_CHK);
   assign accept    = bus.load_valid & ready;
   assign n_hdr     = {n_reg[15:8], bus.load_byte};
   assign wptr_ext  = 16'(wptr_reg);
   assign ram_wdata = make_word(hi_reg, bus.load_byte);

   always_comb begin
      state_next = state_reg;
      n_next     = n_reg;
      count_next = count_reg;
      wptr_next  = wptr_reg;
      hi_next    = hi_reg;
      ram_we     = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_next  = csum_reg;
`endif
      // A new load always wins; any byte presented alongside it is dropped.
      if (bus.load_start) begin
         state_next = ST_HDR_HI;
         n_next     = '0;
         count_next = '0;
         wptr_next  = '0;
`ifdef LOADER_CHECKSUM_EN
         csum_next  = '0;
`endif
      end else if (accept) begin
`ifdef LOADER_CHECKSUM_EN
         csum_next = csum_reg ^ bus.load_byte;
`endif
         case (state_reg)
            ST_HDR_HI: begin
               n_next     = {bus.load_byte, 8'h00};
               state_next = ST_HDR_LO;
            end
            ST_HDR_LO: begin
               n_next = n_hdr;
               if ({1'b0, n_hdr} > MAX_WORDS) begin
                  state_next = ST_ERR;
               end else if (n_hdr == 16'd0) begin
                  state_next = ST_DONE;
               end else begin
                  state_next = ST_DATA_HI;
               end
            end
            ST_DATA_HI: begin
               hi_next    = bus.load_byte;
               state_next = ST_DATA_LO;
            end
            ST_DATA_LO: begin
               ram_we    = 1'b1;
               wptr_next = wptr_reg + WP_W'(1);
               if (wptr_ext == n_reg - 16'd1) begin
                  state_next = ST_DONE;
               end else begin
                  state_next = ST_DATA_HI;
               end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
               state_next = (bus.load_byte == csum_reg) ? ST_RUN : ST_ERR;
            end
`endif
            default: ;
         endcase
      end
      // The fetch window opens only once the whole program is in place.
      if ((state_next == ST_RUN) && (state_reg != ST_RUN)) begin
         count_next = n_next;
      end
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state_reg     <= ST_IDLE;
         n_reg         <= '0;
         count_reg     <= '0;
         wptr_reg      <= '0;
         hi_reg        <= '0;
         cpu_clear_reg <= 1'b1;
         load_done_reg <= 1'b0;
         load_err_reg  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         csum_reg      <= '0;
`endif
      end else begin
         state_reg     <= state_next;
         n_reg         <= n_next;
         count_reg     <= count_next;
         wptr_reg      <= wptr_next;
         hi_reg        <= hi_next;
         // Released one cycle after RUN is reached, so count is stable first.
         cpu_clear_reg <= bus.load_start | (state_reg != ST_RUN);
         load_done_reg <= (state_next == ST_RUN);
         load_err_reg  <= (state_next == ST_ERR);
`ifdef LOADER_CHECKSUM_EN
         csum_reg      <= csum_next;
`endif
      end
   end

   ins_mem_loader_ram #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (wptr_reg[DEPTH_LOG2-1:0]),
      .wdata (ram_wdata),
      .raddr (bus.ins_addr[DEPTH_LOG2-1:0]),
      .rdata (ram_rdata)
   );

   // Full 16-bit compare: addresses past the RAM never alias back into it.
   assign bus.ins        = (bus.ins_addr < count_reg) ? ram_rdata : HALT_WORD;
   assign bus.cpu_clear  = cpu_clear_reg;
   assign bus.load_ready = ready;
   assign bus.load_done  = load_done_reg;
   assign bus.load_err   = load_err_reg;

endmodule

// File: tb/tb_ins_mem_loader.sv
// Directed bench for ins_mem_loader: reset, loads, overflow, abort, gaps, clear mid-load.
// With LOADER_CHECKSUM_EN defined the streams carry a checksum byte and the checksum cases run.
module tb_ins_mem_loader;

   logic clk = 1'b0;
   logic clear;

   always #5 clk = ~clk;

   ins_mem_loader_if bus();

   ins_mem_loader #(
      .DEPTH_LOG2 (8),
      .HALT_WORD  (16'hD000)
   ) dut (
      .clk   (clk),
      .clear (clear),
      .bus   (bus)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  csum;
   logic [15:0] prog [0:255];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one byte, hold it until the loader takes it (bounded), return at posedge+1.
   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int waited;
      if (gaps) begin
         bus.load_valid = 1'b0;
         repeat ($urandom_range(0, 3)) tick();
      end
      bus.load_byte  = b;
      bus.load_valid = 1'b1;
      waited = 0;
      @(negedge clk);
      while (!bus.load_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.load_ready) check_val("ready_wait", 32'(bus.load_ready), 32'd1);
      csum = csum ^ b;
      tick();
      bus.load_valid = 1'b0;
   endtask

   task automatic send_program(input logic [15:0] n, input int n_words, input bit gaps);
`ifdef LOADER_CHECKSUM_EN
      logic [7:0] s;
`endif
      csum = 8'h00;
      send_byte(n[15:8], gaps);
      send_byte(n[7:0], gaps);
      for (int i = 0; i < n_words; i++) begin
         send_byte(prog[i][15:8], gaps);
         send_byte(prog[i][7:0], gaps);
      end
`ifdef LOADER_CHECKSUM_EN
      s = csum;
      send_byte(s, gaps);
`endif
   endtask

   task automatic start_load();
      bus.load_start = 1'b1;
      tick();
      bus.load_start = 1'b0;
   endtask

   task automatic check_ins(input string tag, input logic [15:0] addr, input logic [15:0] exp);
      bus.ins_addr = addr;
      @(negedge clk);
      check_val(tag, 32'(bus.ins), 32'(exp));
      tick();
   endtask

   task automatic set_t2_prog();
      prog[0] = 16'h1234;
      prog[1] = 16'hABCD;
      prog[2] = 16'h0001;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
`ifdef LOADER_CHECKSUM_EN
      logic [7:0] t2_bytes [0:7];
      t2_bytes = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01};
`endif
      clear          = 1'b1;
      bus.load_start = 1'b0;
      bus.load_valid = 1'b0;
      bus.load_byte  = 8'h00;
      bus.ins_addr   = 16'h0000;
      csum           = 8'h00;
      repeat (3) @(posedge clk);
      #1;

      // T1: reset state
      check_val("t1_cpu_clear", 32'(bus.cpu_clear), 32'd1);
      check_val("t1_load_done", 32'(bus.load_done), 32'd0);
      check_val("t1_load_err",  32'(bus.load_err),  32'd0);
      check_val("t1_ready",     32'(bus.load_ready), 32'd0);
      check_val("t1_ins0",      32'(bus.ins), 32'h0000D000);
      clear = 1'b0;
      tick();

      // valid while IDLE is ignored
      bus.load_byte  = 8'h55;
      bus.load_valid = 1'b1;
      repeat (3) tick();
      bus.load_valid = 1'b0;
      check_val("idle_ready", 32'(bus.load_ready), 32'd0);
      check_val("idle_cpu_clear", 32'(bus.cpu_clear), 32'd1);

      // T2: three-word load
      set_t2_prog();
      start_load();
      check_val("t2_start_ready", 32'(bus.load_ready), 32'd1);
      send_program(16'd3, 3, 1'b0);
      check_val("t2_done", 32'(bus.load_done), 32'd1);
      check_val("t2_cpu_clear_lag", 32'(bus.cpu_clear), 32'd1);
      tick();
      check_val("t2_cpu_clear", 32'(bus.cpu_clear), 32'd0);
      check_val("t2_err", 32'(bus.load_err), 32'd0);
      check_val("t2_ready", 32'(bus.load_ready), 32'd0);
      check_ins("t2_ins0", 16'h0000, 16'h1234);
      check_ins("t2_ins1", 16'h0001, 16'hABCD);
      check_ins("t2_ins2", 16'h0002, 16'h0001);
      check_ins("t2_ins3", 16'h0003, 16'hD000);
      check_ins("t2_ins100", 16'h0100, 16'hD000);
      check_ins("t2_insffff", 16'hFFFF, 16'hD000);

      // T3: header overflow (N = 257 with 256-word RAM), starting from RUN
      start_load();
      check_val("t3_start_cpu_clear", 32'(bus.cpu_clear), 32'd1);
      check_val("t3_start_done", 32'(bus.load_done), 32'd0);
      check_ins("t3_start_ins0", 16'h0000, 16'hD000);
      csum = 8'h00;
      send_byte(8'h01, 1'b0);
      send_byte(8'h01, 1'b0);
      check_val("t3_err", 32'(bus.load_err), 32'd1);
      check_val("t3_ready", 32'(bus.load_ready), 32'd0);
      check_val("t3_cpu_clear", 32'(bus.cpu_clear), 32'd1);
      check_val("t3_done", 32'(bus.load_done), 32'd0);
      bus.load_valid = 1'b1;
      repeat (3) tick();
      bus.load_valid = 1'b0;
      check_val("t3_err_sticky", 32'(bus.load_err), 32'd1);
      check_val("t3_ready_sticky", 32'(bus.load_ready), 32'd0);

      // Boundary: exactly 256 words fills the RAM
      for (int i = 0; i < 256; i++) prog[i] = {8'(i), ~8'(i)};
      start_load();
      check_val("full_err_cleared", 32'(bus.load_err), 32'd0);
      send_program(16'd256, 256, 1'b0);
      check_val("full_done", 32'(bus.load_done), 32'd1);
      check_val("full_err", 32'(bus.load_err), 32'd0);
      tick();
      check_ins("full_ins0", 16'h0000, 16'h00FF);
      check_ins("full_ins255", 16'h00FF, 16'hFF00);
      check_ins("full_ins256", 16'h0100, 16'hD000);

      // Boundary: empty program
      start_load();
      send_program(16'd0, 0, 1'b0);
      check_val("empty_done", 32'(bus.load_done), 32'd1);
      tick();
      check_val("empty_cpu_clear", 32'(bus.cpu_clear), 32'd0);
      check_ins("empty_ins0", 16'h0000, 16'hD000);

      // T4: abort mid-load, then a 1-word load; byte alongside load_start is dropped
      set_t2_prog();
      start_load();
      csum = 8'h00;
      send_byte(8'h00, 1'b0);
      send_byte(8'h03, 1'b0);
      send_byte(8'h12, 1'b0);
      send_byte(8'h34, 1'b0);
      send_byte(8'hAB, 1'b0);
      check_val("t4_mid_done", 32'(bus.load_done), 32'd0);
      check_val("t4_mid_cpu_clear", 32'(bus.cpu_clear), 32'd1);
      bus.load_byte  = 8'hFF;
      bus.load_valid = 1'b1;
      start_load();
      bus.load_valid = 1'b0;
      prog[0] = 16'h5555;
      send_program(16'd1, 1, 1'b0);
      check_val("t4_done", 32'(bus.load_done), 32'd1);
      check_val("t4_err", 32'(bus.load_err), 32'd0);
      tick();
      check_ins("t4_ins0", 16'h0000, 16'h5555);
      check_ins("t4_ins1", 16'h0001, 16'hD000);
      check_ins("t4_ins2", 16'h0002, 16'hD000);

      // T5: T2 stream with random valid gaps
      set_t2_prog();
      start_load();
      send_program(16'd3, 3, 1'b1);
      check_val("t5_done", 32'(bus.load_done), 32'd1);
      tick();
      check_val("t5_cpu_clear", 32'(bus.cpu_clear), 32'd0);
      check_ins("t5_ins0", 16'h0000, 16'h1234);
      check_ins("t5_ins1", 16'h0001, 16'hABCD);
      check_ins("t5_ins2", 16'h0002, 16'h0001);
      check_ins("t5_ins3", 16'h0003, 16'hD000);

      // clear asserted mid-load takes effect without a clock edge
      start_load();
      csum = 8'h00;
      send_byte(8'h00, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b0);
      bus.ins_addr = 16'h0000;
      #2;
      clear = 1'b1;
      #1;
      check_val("clr_cpu_clear", 32'(bus.cpu_clear), 32'd1);
      check_val("clr_ready", 32'(bus.load_ready), 32'd0);
      check_val("clr_done", 32'(bus.load_done), 32'd0);
      check_val("clr_ins0", 32'(bus.ins), 32'h0000D000);
      tick();
      clear = 1'b0;
      tick();
      check_val("clr_idle_ready", 32'(bus.load_ready), 32'd0);

`ifdef LOADER_CHECKSUM_EN
      // T6: XOR of 00 03 12 34 AB CD 00 01 is 0x42
      start_load();
      for (int i = 0; i < 8; i++) send_byte(t2_bytes[i], 1'b0);
      send_byte(8'h42, 1'b0);
      check_val("t6_good_done", 32'(bus.load_done), 32'd1);
      check_val("t6_good_err", 32'(bus.load_err), 32'd0);
      tick();
      check_ins("t6_good_ins1", 16'h0001, 16'hABCD);
      start_load();
      for (int i = 0; i < 8; i++) send_byte(t2_bytes[i], 1'b0);
      send_byte(8'h43, 1'b0);
      check_val("t6_bad_err", 32'(bus.load_err), 32'd1);
      check_val("t6_bad_done", 32'(bus.load_done), 32'd0);
      tick();
      check_val("t6_bad_cpu_clear", 32'(bus.cpu_clear), 32'd1);
      check_ins("t6_bad_ins0", 16'h0000, 16'hD000);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
